// File: rtl/apb_pkg.sv
// Shared types and constants for the codec-side APB requester.
package apb_pkg;

    localparam int AMBA_WORD_DEF       = 32;
    localparam int AMBA_ADDR_WIDTH_DEF = 20;

    localparam logic [AMBA_ADDR_WIDTH_DEF-1:0] CTRL_ADDR           = 'h0;
    localparam logic [AMBA_ADDR_WIDTH_DEF-1:0] DATA_IN_ADDR        = 'h4;
    localparam logic [AMBA_ADDR_WIDTH_DEF-1:0] CODEWORD_WIDTH_ADDR = 'h8;
    localparam logic [AMBA_ADDR_WIDTH_DEF-1:0] NOISE_ADDR          = 'hC;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        ACCESS  = 2'd2,
        CAPTURE = 2'd3
    } state_t;

endpackage

// File: rtl/apb_master_if.sv
// Command/response port plus APB bus of the requester.
interface apb_master_if #(
    parameter int AMBA_WORD       = apb_pkg::AMBA_WORD_DEF,
    parameter int AMBA_ADDR_WIDTH = apb_pkg::AMBA_ADDR_WIDTH_DEF
) ();

    logic                       cmd_valid;
    logic                       cmd_ready;
    logic                       cmd_write;
    logic [AMBA_ADDR_WIDTH-1:0] cmd_addr;
    logic [AMBA_WORD-1:0]       cmd_wdata;
    logic                       rsp_valid;
    logic [AMBA_WORD-1:0]       rsp_rdata;
    logic                       rsp_err;
    logic                       busy;
    logic                       PSEL;
    logic                       PENABLE;
    logic                       PWRITE;
    logic [AMBA_ADDR_WIDTH-1:0] PADDR;
    logic [AMBA_WORD-1:0]       PWDATA;
    logic [AMBA_WORD-1:0]       PRDATA;
    logic                       PREADY;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  PRDATA, PREADY,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output PRDATA, PREADY,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

endinterface

// File: rtl/apb_wait_timer.sv
// Access-phase length counter; PREADY timeout under APB_MASTER_TIMEOUT_EN.
module apb_wait_timer #(
    parameter int ACCESS_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    input  logic ready,
    output logic done,
    output logic timeout
);

    localparam int CW = $clog2(ACCESS_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(ACCESS_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(ACCESS_CYCLES - 1);

    if (ACCESS_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("apb_wait_timer: cycle counts must be >= 1");
    end

    logic [CW-1:0] cnt;
    logic          min_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run && cnt < CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign min_done = (cnt >= CNT_LAST);
    assign done     = run && min_done && ready;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] wait_cnt;
    logic          stalled;

    // Counts consecutive not-ready cycles once the minimum access has elapsed.
    assign stalled = run && min_done && !ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (clear || !stalled) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_LAST) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign timeout = stalled && (wait_cnt == WAIT_LAST);
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: rtl/apb_master.sv
// APB requester: one command -> one SETUP/ACCESS(/CAPTURE) transfer.
module apb_master
    import apb_pkg::*;
#(
    parameter int AMBA_WORD       = AMBA_WORD_DEF,
    parameter int AMBA_ADDR_WIDTH = AMBA_ADDR_WIDTH_DEF,
    parameter int ACCESS_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES  = 16
) (
    input  logic clk,
    input  logic rst,
    apb_master_if.master bus
);

    state_t state;

    logic                       psel_q;
    logic                       penable_q;
    logic                       pwrite_q;
    logic [AMBA_ADDR_WIDTH-1:0] paddr_q;
    logic [AMBA_WORD-1:0]       pwdata_q;
    logic                       rsp_valid_q;
    logic                       rsp_err_q;
    logic [AMBA_WORD-1:0]       rsp_rdata_q;

    logic in_setup;
    logic in_access;
    logic acc_done;
    logic acc_timeout;

    assign in_setup  = (state == SETUP);
    assign in_access = (state == ACCESS);

    apb_wait_timer #(
        .ACCESS_CYCLES  (ACCESS_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (in_setup),
        .run     (in_access),
        .ready   (bus.PREADY),
        .done    (acc_done),
        .timeout (acc_timeout)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        pwrite_q <= bus.cmd_write;
                        paddr_q  <= bus.cmd_addr;
                        pwdata_q <= bus.cmd_wdata;
                        psel_q   <= 1'b1;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state     <= ACCESS;
                end
                ACCESS: begin
                    if (acc_done) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        if (pwrite_q) begin
                            rsp_valid_q <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            state <= CAPTURE;
                        end
                    end else if (acc_timeout) begin
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        state       <= IDLE;
                    end
                end
                CAPTURE: begin
                    // Slave PRDATA is registered, so it is settled by now.
                    rsp_rdata_q <= bus.PRDATA;
                    rsp_valid_q <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = rst && (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB requester that drives the codec's APB register slave (CTRL 0x0, DATA_IN 0x4, CODEWORD_WIDTH 0x8, NOISE 0xC) from a simple valid/ready command port.
- Converts one command into one complete APB transfer: IDLE → SETUP → ACCESS (→ CAPTURE for reads). Returns a single-cycle response pulse.
- Used by the host-side wrapper and as the bus driver in block-level benches.
- Access length and read-capture timing are sized for the slave's registered SETUP/ACCES handshake and registered PRDATA.

Parameters:
- AMBA_WORD, 32, data width of PWDATA/PRDATA/cmd_wdata/rsp_rdata.
- AMBA_ADDR_WIDTH, 20, address width of PADDR/cmd_addr.
- ACCESS_CYCLES, 2, minimum cycles PENABLE stays high per transfer (>=1).
- TIMEOUT_CYCLES, 16, PREADY wait limit; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid&&cmd_ready
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  AMBA_ADDR_WIDTH  target address
- cmd_wdata  in  AMBA_WORD  write data
- rsp_valid  out  1  one-cycle completion pulse; no backpressure
- rsp_rdata  out  AMBA_WORD  read data, valid with rsp_valid on reads; holds last value otherwise
- rsp_err  out  1  timeout flag, valid with rsp_valid
- busy  out  1  high whenever state != IDLE
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PADDR  out  AMBA_ADDR_WIDTH  APB address
- PWDATA  out  AMBA_WORD  APB write data
- PRDATA  in  AMBA_WORD  APB read data
- PREADY  in  1  slave ready; tie high for slaves without wait states

Behaviour:
- All APB outputs are registered. Reset value of every output is 0, except cmd_ready, which is 1 when rst is deasserted.
- FSM states: IDLE, SETUP, ACCESS, CAPTURE. Access counter is $clog2(ACCESS_CYCLES+1) bits wide.
- IDLE:
  - PSEL=0, PENABLE=0.
  - On accept, latch cmd_write, cmd_addr and cmd_wdata into PWRITE, PADDR and PWDATA, then go to SETUP.
  - PADDR/PWDATA/PWRITE hold their last values while idle.
- SETUP (1 cycle): PSEL=1, PENABLE=0. Go to ACCESS; clear the counter.
- ACCESS:
  - PSEL=1, PENABLE=1. The counter increments each cycle, saturating at ACCESS_CYCLES.
  - The transfer completes in the cycle where counter>=ACCESS_CYCLES-1 and PREADY=1.
  - On completion: a write goes to IDLE with rsp_valid=1 in the next cycle; a read goes to CAPTURE.
- CAPTURE (reads only, 1 cycle):
  - PSEL=0, PENABLE=0.
  - PRDATA is sampled at the end of this cycle into rsp_rdata; rsp_valid=1 in the next cycle; state goes to IDLE.
- Latency with accept at cycle T and ACCESS_CYCLES=2, PREADY=1:
  - SETUP at T+1; ACCESS at T+2..T+3.
  - Write: rsp_valid at T+4.
  - Read: CAPTURE at T+4, rsp_valid at T+5.
  - cmd_ready returns in the same cycle as rsp_valid, so back-to-back commands are allowed.
- PADDR, PWDATA and PWRITE are stable from SETUP through the end of ACCESS.
- cmd_valid while busy is ignored and nothing is queued. Command inputs may change freely while cmd_ready=0.
- rsp_err=0 without the optional feature.
- Async reset mid-transfer: immediate return to IDLE, all outputs 0, no rsp_valid generated. A transfer interrupted by reset is lost.

Optional Feature:
- Macro APB_MASTER_TIMEOUT_EN.
- When defined, a wait counter runs in ACCESS once the minimum ACCESS_CYCLES has elapsed. If PREADY stays 0 for TIMEOUT_CYCLES consecutive cycles:
  - The transfer aborts: PSEL/PENABLE drop and state goes to IDLE.
  - rsp_valid=1 with rsp_err=1; rsp_rdata is unchanged.
- When undefined, ACCESS waits indefinitely for PREADY and rsp_err is tied to 0.

Decomposition:
- Package apb_pkg holds:
  - the FSM state enum (IDLE, SETUP, ACCESS, CAPTURE);
  - the register address localparams CTRL_ADDR=0x0, DATA_IN_ADDR=0x4, CODEWORD_WIDTH_ADDR=0x8, NOISE_ADDR=0xC;
  - the default AMBA_WORD/AMBA_ADDR_WIDTH constants.
- Sub-module apb_wait_timer holds the access counter plus the timeout counter (its timeout logic is present only under the macro). Everything else is one module.

Test Plan:
- Write cmd_addr=0x4, cmd_wdata=0x0000_00AB with APB_BUS slave, PREADY=1 -> SETUP at T+1, PENABLE at T+2..T+3, rsp_valid at T+4 with rsp_err=0, slave DATA_IN=0xAB.
- Read cmd_addr=0x4 after the write above -> rsp_valid at T+5, rsp_rdata=0x0000_00AB.
- Back-to-back: write CTRL=0x1, then write NOISE=0x5, then read 0xC, with cmd_valid held high -> each accepted in its rsp_valid cycle; slave start pulses once; final rsp_rdata=0x5.
- Hold PREADY=0 for 3 extra cycles during a write -> PENABLE stretched 3 cycles; rsp_valid 3 cycles later; PADDR/PWDATA stable throughout.
- Macro defined, TIMEOUT_CYCLES=16, PREADY stuck 0 -> abort after 16 wait cycles with rsp_valid=1, rsp_err=1, state IDLE, cmd_ready=1.
- Assert rst during ACCESS of a read -> PSEL=PENABLE=0 immediately; no rsp_valid; a next command after reset completes normally.
